// File: rtl/parking_gate_sensor_pkg.sv
// Shared encodings for the parking gate sensor decoder: FSM state codes,
// debounced sensor-pair codes and synchronizer depth.
package parking_gate_sensor_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN_A  = 3'd1,
        EN_AB = 3'd2,
        EN_B  = 3'd3,
        EX_B  = 3'd4,
        EX_AB = 3'd5,
        EX_A  = 3'd6,
        ERR   = 3'd7
    } state_t;

    // Pair codes are {db_a, db_b}; 1 means the beam is blocked.
    localparam logic [1:0] P_CLR = 2'b00;
    localparam logic [1:0] P_A   = 2'b10;
    localparam logic [1:0] P_B   = 2'b01;
    localparam logic [1:0] P_AB  = 2'b11;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/parking_gate_sensor_if.sv
// Gate-side signal bundle: raw beam inputs toward the decoder and the
// occupancy pulses/status coming back.
interface parking_gate_sensor_if;

    logic sens_a;
    logic sens_b;
    logic inc;
    logic dec;
    logic seq_err;
    logic busy;

    modport master (
        output sens_a,
        output sens_b,
        input  inc,
        input  dec,
        input  seq_err,
        input  busy
    );

    modport slave (
        input  sens_a,
        input  sens_b,
        output inc,
        output dec,
        output seq_err,
        output busy
    );

endinterface

// File: rtl/parking_gate_sensor_debounce.sv
// Two-flop synchronizer followed by a hold-time debouncer: the output level
// only follows the synchronized input after it has been stable long enough.
module sensor_debounce
    import parking_gate_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_lvl;
    logic                   db_q;
    logic                   db_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;

    assign sync_d[0] = raw;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    assign s_lvl = sync_q[SYNC_STAGES-1];

    // Any sample matching the current level restarts the count, so a
    // glitch shorter than DEBOUNCE_CYCLES never reaches the output.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (s_lvl == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = s_lvl;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = db_q;

endmodule

// File: rtl/parking_gate_sensor.sv
// Decodes the outer (A) and inner (B) gate beams into registered car-entered,
// car-exited and sequence-error pulses for the lot occupancy counter.
module parking_gate_sensor
    import parking_gate_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    parking_gate_sensor_if.slave  gate
);

    logic   db_a;
    logic   db_b;
    logic   [1:0] p;
    state_t state_q;
    state_t state_d;
    logic   inc_q;
    logic   inc_d;
    logic   dec_q;
    logic   dec_d;
    logic   err_q;
    logic   err_d;
    logic   busy_q;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .raw   (gate.sens_a),
        .level (db_a)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .raw   (gate.sens_b),
        .level (db_b)
    );

    assign p = {db_a, db_b};

    always_comb begin
        state_d = state_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                case (p)
                    P_A:     state_d = EN_A;
                    P_B:     state_d = EX_B;
                    P_AB:    state_d = ERR;
                    default: state_d = IDLE;
                endcase
            end
            EN_A: begin
                case (p)
                    P_AB:    state_d = EN_AB;
                    P_CLR:   state_d = IDLE;
                    P_B:     state_d = ERR;
                    default: state_d = EN_A;
                endcase
            end
            EN_AB: begin
                case (p)
                    P_B:     state_d = EN_B;
                    P_A:     state_d = EN_A;
                    P_CLR:   state_d = ERR;
                    default: state_d = EN_AB;
                endcase
            end
            EN_B: begin
                case (p)
                    P_CLR: begin
                        state_d = IDLE;
                        inc_d   = 1'b1;
                    end
                    P_AB:    state_d = EN_AB;
                    P_A:     state_d = ERR;
                    default: state_d = EN_B;
                endcase
            end
            EX_B: begin
                case (p)
                    P_AB:    state_d = EX_AB;
                    P_CLR:   state_d = IDLE;
                    P_A:     state_d = ERR;
                    default: state_d = EX_B;
                endcase
            end
            EX_AB: begin
                case (p)
                    P_A:     state_d = EX_A;
                    P_B:     state_d = EX_B;
                    P_CLR:   state_d = ERR;
                    default: state_d = EX_AB;
                endcase
            end
            EX_A: begin
                case (p)
                    P_CLR: begin
                        state_d = IDLE;
                        dec_d   = 1'b1;
                    end
                    P_AB:    state_d = EX_AB;
                    P_B:     state_d = ERR;
                    default: state_d = EX_A;
                endcase
            end
            ERR: begin
                if (p == P_CLR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // seq_err marks only the entry edge into ERR, not the dwell there.
    assign err_d = (state_d == ERR) && (state_q != ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign gate.inc     = inc_q;
    assign gate.dec     = dec_q;
    assign gate.seq_err = err_q;
    assign gate.busy    = busy_q;

endmodule

// File: tb/tb_parking_gate_sensor.sv
// Directed bench for the parking gate sensor decoder with DEBOUNCE_CYCLES=4.
module tb_parking_gate_sensor;
    import parking_gate_sensor_pkg::*;

    localparam int DB = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;

    int   inc_cnt, dec_cnt, err_cnt, multi_cnt, busy_cnt, dba_changes;
    int   inc_cyc, dec_cyc;
    logic inc_busy;
    logic dba_prev;
    int   drive_cyc;
    int   inc0, dec0, err0;

    parking_gate_sensor_if gate_if ();

    parking_gate_sensor #(.DEBOUNCE_CYCLES(DB)) u_dut (
        .clk   (clk),
        .reset (reset),
        .gate  (gate_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (gate_if.inc) begin
                inc_cnt  = inc_cnt + 1;
                inc_cyc  = cyc;
                inc_busy = gate_if.busy;
            end
            if (gate_if.dec) begin
                dec_cnt = dec_cnt + 1;
                dec_cyc = cyc;
            end
            if (gate_if.seq_err) err_cnt = err_cnt + 1;
            if ((32'(gate_if.inc) + 32'(gate_if.dec) + 32'(gate_if.seq_err)) > 1)
                multi_cnt = multi_cnt + 1;
            if (gate_if.busy) busy_cnt = busy_cnt + 1;
            if (u_dut.db_a != dba_prev) dba_changes = dba_changes + 1;
        end
        dba_prev = u_dut.db_a;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0d", tag, got);
        end
    endtask

    task automatic drive(input logic a, input logic b);
        @(posedge clk);
        #1;
        gate_if.sens_a = a;
        gate_if.sens_b = b;
        drive_cyc = cyc;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        inc0 = inc_cnt;
        dec0 = dec_cnt;
        err0 = err_cnt;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; cyc = 0;
        inc_cnt = 0; dec_cnt = 0; err_cnt = 0; multi_cnt = 0; busy_cnt = 0;
        dba_changes = 0; inc_cyc = 0; dec_cyc = 0; inc_busy = 1'b1; dba_prev = 1'b0;
        drive_cyc = 0; inc0 = 0; dec0 = 0; err0 = 0;
        reset = 1'b1;
        gate_if.sens_a = 1'b0;
        gate_if.sens_b = 1'b0;

        // Reset state
        hold(3);
        sample();
        chk("rst_inc", 32'(gate_if.inc), 0);
        chk("rst_dec", 32'(gate_if.dec), 0);
        chk("rst_err", 32'(gate_if.seq_err), 0);
        chk("rst_busy", 32'(gate_if.busy), 0);
        @(posedge clk); #1; reset = 1'b0;
        hold(4);

        // Entry: A, AB, B, clear
        snap();
        drive(1, 0); hold(10); sample();
        chk("entry_busy_en_a", 32'(gate_if.busy), 1);
        drive(1, 1); hold(10);
        drive(0, 1); hold(10); sample();
        chk("entry_busy_en_b", 32'(gate_if.busy), 1);
        drive(0, 0); hold(12); sample();
        chk("entry_inc", 32'(inc_cnt - inc0), 1);
        chk("entry_dec", 32'(dec_cnt - dec0), 0);
        chk("entry_err", 32'(err_cnt - err0), 0);
        chk("entry_latency", 32'(inc_cyc - drive_cyc), 32'(2 + DB + 1));
        chk("entry_busy_at_inc", 32'(inc_busy), 0);
        chk("entry_busy_after", 32'(gate_if.busy), 0);

        // Exit: B, AB, A, clear
        snap();
        drive(0, 1); hold(10);
        drive(1, 1); hold(10);
        drive(1, 0); hold(10);
        drive(0, 0); hold(12); sample();
        chk("exit_dec", 32'(dec_cnt - dec0), 1);
        chk("exit_inc", 32'(inc_cnt - inc0), 0);
        chk("exit_latency", 32'(dec_cyc - drive_cyc), 32'(2 + DB + 1));
        chk("exit_state_idle", 32'(u_dut.state_q), 32'(IDLE));

        // Abort and reverse: A, AB, A, clear then a full entry
        snap();
        drive(1, 0); hold(10);
        drive(1, 1); hold(10);
        drive(1, 0); hold(10);
        drive(0, 0); hold(12); sample();
        chk("abort_inc", 32'(inc_cnt - inc0), 0);
        chk("abort_dec", 32'(dec_cnt - dec0), 0);
        chk("abort_err", 32'(err_cnt - err0), 0);
        snap();
        drive(1, 0); hold(10);
        drive(1, 1); hold(10);
        drive(0, 1); hold(10);
        drive(0, 0); hold(12); sample();
        chk("reentry_inc", 32'(inc_cnt - inc0), 1);

        // Glitch rejection: 3-cycle pulse on A while idle
        snap();
        busy_cnt = 0;
        dba_changes = 0;
        drive(1, 0); hold(2);
        drive(0, 0); hold(12); sample();
        chk("glitch_db_a", 32'(dba_changes), 0);
        chk("glitch_busy", 32'(busy_cnt), 0);
        chk("glitch_pulses", 32'((inc_cnt - inc0) + (dec_cnt - dec0) + (err_cnt - err0)), 0);

        // Illegal jump: both beams at once, then B, clear, then an exit
        snap();
        drive(1, 1); hold(10); sample();
        chk("illegal_err", 32'(err_cnt - err0), 1);
        drive(0, 1); hold(10);
        drive(0, 0); hold(12); sample();
        chk("illegal_err_once", 32'(err_cnt - err0), 1);
        chk("illegal_no_dec", 32'(dec_cnt - dec0), 0);
        chk("illegal_idle", 32'(gate_if.busy), 0);
        snap();
        drive(0, 1); hold(10);
        drive(1, 1); hold(10);
        drive(1, 0); hold(10);
        drive(0, 0); hold(12); sample();
        chk("after_err_dec", 32'(dec_cnt - dec0), 1);

        // Reset while in EN_B, then clear
        snap();
        drive(1, 0); hold(10);
        drive(1, 1); hold(10);
        drive(0, 1); hold(10);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        gate_if.sens_a = 1'b0;
        gate_if.sens_b = 1'b0;
        sample();
        chk("midrst_inc", 32'(gate_if.inc), 0);
        chk("midrst_dec", 32'(gate_if.dec), 0);
        chk("midrst_err", 32'(gate_if.seq_err), 0);
        chk("midrst_busy", 32'(gate_if.busy), 0);
        hold(12); sample();
        chk("midrst_no_inc", 32'(inc_cnt - inc0), 0);
        chk("midrst_idle", 32'(gate_if.busy), 0);

        chk("one_hot_pulses", 32'(multi_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
